// File: rtl/component_pipe_arbiter.sv
// component_pipe_arbiter: two-way round-robin front end for a shared unit
// with fixed latency. Optional grant counters: COMPONENT_PIPE_ARBITER_STATS_EN.
module component_pipe_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             flush,
  output logic             issue_valid,
  output logic [WIDTH-1:0] issue_data,
  input  logic [WIDTH-1:0] pipe_result,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data
`ifdef COMPONENT_PIPE_ARBITER_STATS_EN
  ,
  output logic [15:0]      grant0_count,
  output logic [15:0]      grant1_count
`endif
);

  // ptr=1 means requester 1 was granted last
  logic ptr;
  logic pick0;
  logic pick1;
  logic xfer0;
  logic xfer1;
  logic xfer;

  // tag pipeline: stage k is the owner of the issue k cycles old
  logic [LATENCY:0] tag_v;
  logic [LATENCY:0] tag_id;

  // grant the lone requester, or on a tie the one not served last
  always_comb begin
    pick0      = req0_valid && (!req1_valid || ptr);
    pick1      = req1_valid && (!req0_valid || !ptr);
    req0_ready = pick0 && !flush;
    req1_ready = pick1 && !flush;
  end

  assign xfer0 = req0_valid && req0_ready;
  assign xfer1 = req1_valid && req1_ready;
  assign xfer  = xfer0 || xfer1;

  // pointer moves only on an accepted transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b1;
    end else if (xfer) begin
      ptr <= xfer1;
    end
  end

  // register the granted operand toward the shared unit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid <= 1'b0;
      issue_data  <= '0;
    end else begin
      issue_valid <= xfer;
      if (xfer) begin
        issue_data <= xfer1 ? req1_data : req0_data;
      end
    end
  end

  // owner tags advance every cycle; flush kills every stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= xfer;
      tag_id[0] <= xfer1;
      for (int k = 1; k <= LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1] && !flush;
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign rsp0_valid = tag_v[LATENCY] && !tag_id[LATENCY];
  assign rsp1_valid = tag_v[LATENCY] && tag_id[LATENCY];
  assign rsp_data   = pipe_result;

`ifdef COMPONENT_PIPE_ARBITER_STATS_EN
  // saturating per-requester grant counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant0_count <= '0;
      grant1_count <= '0;
    end else begin
      if (xfer0 && grant0_count != 16'hFFFF) begin
        grant0_count <= grant0_count + 16'd1;
      end
      if (xfer1 && grant1_count != 16'hFFFF) begin
        grant1_count <= grant1_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_component_pipe_arbiter.sv
// tb_component_pipe_arbiter: directed and random checks against
// a queue-based reference model of the arbiter.
module tb_component_pipe_arbiter;
  localparam int W   = 8;
  localparam int LAT = 4;
  localparam logic [W-1:0] XK = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         v0, v1, flush;
  logic [W-1:0] d0, d1;
  logic         r0, r1, iv, rv0, rv1;
  logic [W-1:0] idata, pres, rdata;
`ifdef COMPONENT_PIPE_ARBITER_STATS_EN
  logic [15:0]  cnt0, cnt1;
`endif

  component_pipe_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .flush(flush),
    .issue_valid(iv), .issue_data(idata),
    .pipe_result(pres),
    .rsp0_valid(rv0), .rsp1_valid(rv1), .rsp_data(rdata)
`ifdef COMPONENT_PIPE_ARBITER_STATS_EN
    , .grant0_count(cnt0), .grant1_count(cnt1)
`endif
  );

  // shared unit stand-in: xor with a key, LAT cycles late
  generate
    if (LAT == 0) begin : g_comb
      assign pres = idata ^ XK;
    end else begin : g_dly
      logic [W-1:0] dl [LAT];
      always @(posedge clk) begin
        dl[0] <= idata;
        for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
      end
      assign pres = dl[LAT-1] ^ XK;
    end
  endgenerate

  typedef struct {
    int           due;
    logic         id;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t q[$];
  logic gq[$];
  logic rq[$];
  int   rcq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int obs_rsp = 0;
  int obs1 = 0;
  int rsp0_cyc = -1;
  int m_c0, m_c1;
  logic m_last, m_iv, m_x0, m_x1;
  logic [W-1:0] m_id;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = 1'b1;
    m_iv = 1'b0;
    m_id = '0;
    m_c0 = 0;
    m_c1 = 0;
    m_x0 = 1'b0;
    m_x1 = 1'b0;
  endtask

  task automatic sample();
    logic e0, e1, er0, er1;
    logic [W-1:0] ed;
    rsp_t t;
    er0 = 1'b0;
    er1 = 1'b0;
    ed = '0;
    e0 = 1'b0;
    e1 = 1'b0;
    if (rst) begin
      e0 = !flush && v0 && (!v1 || m_last);
      e1 = !flush && v1 && (!v0 || !m_last);
      chk("req0_ready", r0, e0);
      chk("req1_ready", r1, e1);
      if (r0 || r1) gq.push_back(r1);
    end
    m_x0 = e0;
    m_x1 = e1;
    chk("issue_valid", iv, m_iv);
    chk("issue_data", idata, m_id);
    if (q.size() > 0 && q[0].due == cyc) begin
      t = q.pop_front();
      er0 = !t.id;
      er1 = t.id;
      ed = t.data ^ XK;
    end
    chk("rsp0_valid", rv0, er0);
    chk("rsp1_valid", rv1, er1);
    if (er0 || er1) chk("rsp_data", rdata, ed);
    if (rv0 || rv1) begin
      obs_rsp++;
      rq.push_back(rv1);
      rcq.push_back(cyc);
    end
    if (rv1) obs1++;
    if (rv0 && rsp0_cyc < 0) rsp0_cyc = cyc;
`ifdef COMPONENT_PIPE_ARBITER_STATS_EN
    chk("grant0_count", cnt0, m_c0);
    chk("grant1_count", cnt1, m_c1);
`endif
  endtask

  task automatic update();
    logic [W-1:0] dd;
    cyc++;
    if (!rst) begin
      model_reset();
    end else if (flush) begin
      q.delete();
      m_iv = 1'b0;
    end else if (m_x0 || m_x1) begin
      dd = m_x1 ? d1 : d0;
      m_iv = 1'b1;
      m_id = dd;
      m_last = m_x1;
      q.push_back('{due: cyc + LAT, id: m_x1, data: dd});
      if (m_x0 && m_c0 < 65535) m_c0++;
      if (m_x1 && m_c1 < 65535) m_c1++;
    end else begin
      m_iv = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle();
    v0 = 1'b0;
    v1 = 1'b0;
    flush = 1'b0;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b0;
    #1;
    model_reset();
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic clear_logs();
    gq.delete();
    rq.delete();
    rcq.delete();
  endtask

  initial begin
    logic [5:0] gp, rp;
    logic [3:0] g4;
    int n0, tx;
    rst = 1'b0;
    idle();
    d0 = '0;
    d1 = '0;
    model_reset();
    #2;
    chk("rst_issue_valid", iv, 1'b0);
    chk("rst_issue_data", idata, 8'h00);
    chk("rst_rsp0", rv0, 1'b0);
    chk("rst_rsp1", rv1, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();

    // single req0 transfer
    pulse_reset(2);
    obs1 = 0;
    rsp0_cyc = -1;
    v0 = 1'b1;
    d0 = 8'h5A;
    step();
    tx = cyc;
    v0 = 1'b0;
    chk("t028_issue_valid", iv, 1'b1);
    chk("t028_issue_data", idata, 8'h5A);
    repeat (10) step();
    chk("t028_latency", rsp0_cyc - tx + 1, 5);
    chk("t028_no_rsp1", obs1, 0);

    // tie alternation
    pulse_reset(2);
    clear_logs();
    v0 = 1'b1;
    v1 = 1'b1;
    d0 = 8'h10;
    d1 = 8'h20;
    repeat (6) step();
    idle();
    repeat (8) step();
    gp = '0;
    rp = '0;
    foreach (gq[i]) if (i < 6) gp[i] = gq[i];
    foreach (rq[i]) if (i < 6) rp[i] = rq[i];
    chk("t029_grants", gp, 6'b101010);
    chk("t029_rsp_order", rp, 6'b101010);
    chk("t029_rsp_count", rq.size(), 6);
    if (rcq.size() == 6) chk("t029_rsp_span", rcq[5] - rcq[0], 5);

    // req1 alone, then tie goes to req0
    clear_logs();
    v1 = 1'b1;
    repeat (3) step();
    v0 = 1'b1;
    step();
    idle();
    repeat (6) step();
    g4 = '0;
    foreach (gq[i]) if (i < 4) g4[i] = gq[i];
    chk("t030_grants", g4, 4'b0111);

    // flush kills in-flight ops
    pulse_reset(2);
    n0 = obs_rsp;
    v0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d0 = 8'(i + 8'h31);
      step();
    end
    v0 = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    v0 = 1'b1;
    d0 = 8'hC3;
    step();
    v0 = 1'b0;
    repeat (10) step();
    chk("t031_rsp_count", obs_rsp - n0, 1);

    // reset mid-stream
    pulse_reset(2);
    n0 = obs_rsp;
    v0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0 = 8'(i + 8'h71);
      step();
    end
    v0 = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    chk("t032_issue_valid", iv, 1'b0);
    chk("t032_issue_data", idata, 8'h00);
    chk("t032_rsp0", rv0, 1'b0);
    chk("t032_rsp1", rv1, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    repeat (10) step();
    chk("t032_no_stale", obs_rsp - n0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      v0 = ($urandom_range(9) < 6);
      v1 = ($urandom_range(9) < 6);
      d0 = W'($urandom);
      d1 = W'($urandom);
      flush = ($urandom_range(19) == 0);
      if ($urandom_range(199) == 0) pulse_reset(1);
      step();
    end
    idle();
    repeat (LAT + 3) step();

`ifdef COMPONENT_PIPE_ARBITER_STATS_EN
    pulse_reset(2);
    v0 = 1'b1;
    repeat (70000) begin
      d0 = W'($urandom);
      step();
    end
    idle();
    step();
    chk("t033_grant0_sat", cnt0, 16'hFFFF);
    chk("t033_grant1_zero", cnt1, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
